// File: rtl/maze_pkg.sv
// Shared constants, state encoding and helpers for the maze path checker.
package maze_pkg;

   localparam int unsigned MAZE_WIDTH = 17;
   localparam int unsigned MAZE_CELLS = MAZE_WIDTH * MAZE_WIDTH;
   localparam int unsigned MAX_STEPS  = 288;
   localparam int unsigned TIMEOUT    = 4096;
   localparam int unsigned CNT_WIDTH  = 13;
   localparam int unsigned POS_W      = 5;
   localparam int unsigned STEP_W     = 9;
   localparam int unsigned CELL_W     = 9;
   localparam int unsigned ERR_W      = 3;

   localparam logic [POS_W-1:0] POS_LAST = POS_W'(MAZE_WIDTH - 1);

   localparam logic [1:0] DIR_RIGHT = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_UP    = 2'd3;

   localparam logic [ERR_W-1:0] ERR_NONE       = 3'd0;
   localparam logic [ERR_W-1:0] ERR_TIMEOUT    = 3'd1;
   localparam logic [ERR_W-1:0] ERR_OOB        = 3'd2;
   localparam logic [ERR_W-1:0] ERR_WALL       = 3'd3;
   localparam logic [ERR_W-1:0] ERR_REVISIT    = 3'd4;
   localparam logic [ERR_W-1:0] ERR_NOT_AT_END = 3'd5;
   localparam logic [ERR_W-1:0] ERR_TOO_LONG   = 3'd6;
   localparam logic [ERR_W-1:0] ERR_PROTOCOL   = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT,
      ST_CHECK,
      ST_REPORT
   } state_e;

   // Row-major linear index of cell (x,y).
   function automatic logic [CELL_W-1:0] cell_idx(input logic [POS_W-1:0] x,
                                                  input logic [POS_W-1:0] y);
      return CELL_W'(x) * CELL_W'(MAZE_WIDTH) + CELL_W'(y);
   endfunction

endpackage

// File: rtl/maze_serializer.sv
// Maze storage, row loader, bit-serial transmitter and wall lookup.
module maze_serializer
   import maze_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_en_i,
   input  logic [MAZE_WIDTH-1:0] load_row_i,
   input  logic                  tx_start_i,
   input  logic                  tx_abort_i,
   input  logic [POS_W-1:0]      chk_x_i,
   input  logic [POS_W-1:0]      chk_y_i,
   output logic                  loaded_o,
   output logic                  maze_valid_o,
   output logic                  maze_bit_o,
   output logic                  tx_last_c,
   output logic                  is_open_c
);

   logic [MAZE_WIDTH-1:0] rows_q [MAZE_WIDTH];
   logic [POS_W-1:0]      row_q;
   logic                  loaded_q;
   logic [POS_W-1:0]      tx_x_q;
   logic [POS_W-1:0]      tx_y_q;
   logic                  valid_q;
   logic                  bit_q;
   logic [POS_W-1:0]      tx_x_d;
   logic [POS_W-1:0]      tx_y_d;

   assign loaded_o     = loaded_q;
   assign maze_valid_o = valid_q;
   assign maze_bit_o   = bit_q;

   // Next row-major transmit coordinate and end-of-maze detect.
   always_comb begin
      tx_x_d = tx_x_q;
      tx_y_d = tx_y_q + POS_W'(1);
      if (tx_y_q == POS_LAST) begin
         tx_x_d = tx_x_q + POS_W'(1);
         tx_y_d = '0;
      end
      tx_last_c = valid_q && (tx_x_q == POS_LAST) && (tx_y_q == POS_LAST);
   end

   // Wall lookup for the checker; anything outside the grid reads as wall.
   always_comb begin
      is_open_c = 1'b0;
      if ((chk_x_i <= POS_LAST) && (chk_y_i <= POS_LAST)) begin
         is_open_c = rows_q[chk_x_i][chk_y_i];
      end
   end

   // Row loading and the 289-cycle serial transmit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(MAZE_WIDTH); i++) begin
            rows_q[i] <= '0;
         end
         row_q    <= '0;
         loaded_q <= 1'b0;
         tx_x_q   <= '0;
         tx_y_q   <= '0;
         valid_q  <= 1'b0;
         bit_q    <= 1'b0;
      end else begin
         if (load_en_i) begin
            rows_q[row_q] <= load_row_i;
            if (row_q == POS_LAST) begin
               row_q    <= '0;
               loaded_q <= 1'b1;
            end else begin
               row_q <= row_q + POS_W'(1);
            end
         end
         if (tx_start_i) begin
            valid_q <= 1'b1;
            bit_q   <= rows_q[0][0];
            tx_x_q  <= '0;
            tx_y_q  <= '0;
         end else if (valid_q) begin
            if (tx_abort_i || tx_last_c) begin
               valid_q <= 1'b0;
               bit_q   <= 1'b0;
               tx_x_q  <= '0;
               tx_y_q  <= '0;
            end else begin
               tx_x_q <= tx_x_d;
               tx_y_q <= tx_y_d;
               bit_q  <= rows_q[tx_x_d][tx_y_d];
            end
         end
      end
   end

endmodule

// File: rtl/maze_path_checker.sv
// Stimulus/checker partner of the maze solver: sends the maze, checks the path.
module maze_path_checker
   import maze_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_valid,
   input  logic [MAZE_WIDTH-1:0] load_row,
   output logic                  load_ready,
   input  logic                  start,
   output logic                  maze_valid,
   output logic                  maze_bit,
   input  logic                  path_valid,
   input  logic [1:0]            path_dir,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_code,
   output logic [STEP_W-1:0]     step_count
);

   state_e                 state_q;
   logic                   load_ready_q;
   logic                   done_q;
   logic                   pass_q;
   logic [ERR_W-1:0]       err_q;
   logic [STEP_W-1:0]      step_q;
   logic [POS_W-1:0]       px_q;
   logic [POS_W-1:0]       py_q;
   logic [MAZE_CELLS-1:0]  visited_q;
   logic [CNT_WIDTH-1:0]   cnt_q;

   logic                   loaded_c;
   logic                   tx_last_c;
   logic                   is_open_c;
   logic                   load_en_c;
   logic                   tx_start_c;
   logic                   tx_abort_c;
   logic                   accept_c;
   logic                   oob_c;
   logic [CELL_W-1:0]      cell_c;
   logic [ERR_W-1:0]       dir_err_c;
   logic [ERR_W-1:0]       final_err_c;
   logic [POS_W-1:0]       px_d;
   logic [POS_W-1:0]       py_d;
   logic [STEP_W-1:0]      step_d;
   logic [ERR_W-1:0]       err_d;
   logic [CNT_WIDTH-1:0]   cnt_d;

   assign load_ready = load_ready_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_code   = err_q;
   assign step_count = step_q;

   assign load_en_c  = load_valid && load_ready_q && (state_q == ST_IDLE);
   assign tx_start_c = (state_q == ST_IDLE) && start && loaded_c;
   assign tx_abort_c = (state_q == ST_SEND) && path_valid;
   assign accept_c   = path_valid && ((state_q == ST_WAIT) || (state_q == ST_CHECK));
   assign cnt_d      = cnt_q + CNT_WIDTH'(1);

   maze_serializer u_ser (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_en_i    (load_en_c),
      .load_row_i   (load_row),
      .tx_start_i   (tx_start_c),
      .tx_abort_i   (tx_abort_c),
      .chk_x_i      (px_d),
      .chk_y_i      (py_d),
      .loaded_o     (loaded_c),
      .maze_valid_o (maze_valid),
      .maze_bit_o   (maze_bit),
      .tx_last_c    (tx_last_c),
      .is_open_c    (is_open_c)
   );

   // Evaluate one direction: bounds first, then wall, revisit and length.
   always_comb begin
      px_d  = px_q;
      py_d  = py_q;
      oob_c = 1'b0;
      case (path_dir)
         DIR_RIGHT: if (py_q == POS_LAST) oob_c = 1'b1; else py_d = py_q + POS_W'(1);
         DIR_DOWN:  if (px_q == POS_LAST) oob_c = 1'b1; else px_d = px_q + POS_W'(1);
         DIR_LEFT:  if (py_q == '0)       oob_c = 1'b1; else py_d = py_q - POS_W'(1);
         default:   if (px_q == '0)       oob_c = 1'b1; else px_d = px_q - POS_W'(1);
      endcase
      cell_c = cell_idx(px_d, py_d);
      step_d = (step_q == '1) ? step_q : step_q + STEP_W'(1);
      if (oob_c) begin
         dir_err_c = ERR_OOB;
      end else if (!is_open_c) begin
         dir_err_c = ERR_WALL;
      end else if (visited_q[cell_c]) begin
         dir_err_c = ERR_REVISIT;
      end else if (step_d > STEP_W'(MAX_STEPS)) begin
         dir_err_c = ERR_TOO_LONG;
      end else begin
         dir_err_c = ERR_NONE;
      end
      err_d = (err_q != ERR_NONE) ? err_q : dir_err_c;
      if (err_q != ERR_NONE) begin
         final_err_c = err_q;
      end else if ((px_q == POS_LAST) && (py_q == POS_LAST)) begin
         final_err_c = ERR_NONE;
      end else begin
         final_err_c = ERR_NOT_AT_END;
      end
   end

   // Control FSM with registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         load_ready_q <= 1'b1;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_q        <= ERR_NONE;
         step_q       <= '0;
         px_q         <= '0;
         py_q         <= '0;
         visited_q    <= '0;
         cnt_q        <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               load_ready_q <= 1'b1;
               if (tx_start_c) begin
                  state_q      <= ST_SEND;
                  load_ready_q <= 1'b0;
                  pass_q       <= 1'b0;
                  err_q        <= ERR_NONE;
                  step_q       <= '0;
                  px_q         <= '0;
                  py_q         <= '0;
                  visited_q    <= MAZE_CELLS'(1);
               end
            end
            ST_SEND: begin
               if (path_valid) begin
                  err_q   <= ERR_PROTOCOL;
                  state_q <= ST_WAIT;
                  cnt_q   <= '0;
               end else if (tx_last_c) begin
                  state_q <= ST_WAIT;
                  cnt_q   <= '0;
               end
            end
            ST_WAIT: begin
               if (path_valid) begin
                  state_q <= ST_CHECK;
               end else if (cnt_d == CNT_WIDTH'(TIMEOUT)) begin
                  state_q <= ST_REPORT;
                  done_q  <= 1'b1;
                  pass_q  <= 1'b0;
                  err_q   <= (err_q == ERR_NONE) ? ERR_TIMEOUT : err_q;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_CHECK: begin
               if (!path_valid) begin
                  state_q <= ST_REPORT;
                  done_q  <= 1'b1;
                  err_q   <= final_err_c;
                  pass_q  <= (final_err_c == ERR_NONE);
               end
            end
            ST_REPORT: begin
               state_q      <= ST_IDLE;
               load_ready_q <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
         if (accept_c) begin
            px_q   <= px_d;
            py_q   <= py_d;
            step_q <= step_d;
            err_q  <= err_d;
            if (!oob_c) begin
               visited_q[cell_c] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_maze_path_checker.sv
// Directed bench for maze_path_checker with bit and result scoreboards.
module tb_maze_path_checker;

   localparam int N_SIDE   = 17;
   localparam int N_CELLS  = 289;
   localparam int T_OUT    = 4096;

   typedef struct packed {
      logic [2:0] err;
      logic       pass;
      logic [8:0] steps;
   } exp_res_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_valid;
   logic [16:0] load_row;
   logic        load_ready;
   logic        start;
   logic        maze_valid;
   logic        maze_bit;
   logic        path_valid;
   logic [1:0]  path_dir;
   logic        done;
   logic        pass;
   logic [2:0]  err_code;
   logic [8:0]  step_count;

   int checks = 0;
   int errors = 0;

   logic [16:0] maze_m [N_SIDE];
   logic        exp_bits [$];
   exp_res_t    exp_q [$];

   maze_path_checker dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_row   (load_row),
      .load_ready (load_ready),
      .start      (start),
      .maze_valid (maze_valid),
      .maze_bit   (maze_bit),
      .path_valid (path_valid),
      .path_dir   (path_dir),
      .done       (done),
      .pass       (pass),
      .err_code   (err_code),
      .step_count (step_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Serial bit scoreboard: every valid cycle consumes one expected bit.
   always @(negedge clk) begin
      if (maze_valid) begin
         check("bits_pending", 32'(exp_bits.size() != 0), 32'd1);
         if (exp_bits.size() != 0) begin
            check("maze_bit", 32'(maze_bit), 32'(exp_bits.pop_front()));
         end
      end
   end

   task automatic fill_open();
      for (int i = 0; i < N_SIDE; i++) maze_m[i] = 17'h1FFFF;
   endtask

   task automatic load_maze();
      for (int i = 0; i < N_SIDE; i++) begin
         load_valid = 1'b1;
         load_row   = maze_m[i];
         @(negedge clk);
      end
      load_valid = 1'b0;
      load_row   = '0;
   endtask

   task automatic push_exp(input logic [2:0] e, input logic p, input logic [8:0] s);
      exp_res_t r;
      r.err   = e;
      r.pass  = p;
      r.steps = s;
      exp_q.push_back(r);
   endtask

   task automatic do_start(input bit push_bits);
      logic [16:0] row;
      if (push_bits) begin
         for (int x = 0; x < N_SIDE; x++) begin
            row = maze_m[x];
            for (int y = 0; y < N_SIDE; y++) exp_bits.push_back(row[y]);
         end
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_send(output int len);
      int g = 0;
      len = 0;
      while (!maze_valid && g < 20) begin
         @(negedge clk);
         g++;
      end
      while (maze_valid && len < 400) begin
         len++;
         @(negedge clk);
      end
   endtask

   task automatic drive_dirs(input logic [1:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         path_valid = 1'b1;
         path_dir   = d;
         @(negedge clk);
      end
   endtask

   task automatic end_path();
      path_valid = 1'b0;
      path_dir   = 2'd0;
   endtask

   task automatic wait_done(input string tag, output int cyc);
      exp_res_t e;
      cyc = 0;
      while (!done && cyc < 6000) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      check({tag, "_sb_pending"}, 32'(exp_q.size()), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_err_code"}, 32'(err_code), 32'(e.err));
         check({tag, "_pass"}, 32'(pass), 32'(e.pass));
         check({tag, "_step_count"}, 32'(step_count), 32'(e.steps));
      end
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      int cyc;
      int seen_v;
      int seen_d;
      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_row   = '0;
      start      = 1'b0;
      path_valid = 1'b0;
      path_dir   = 2'd0;
      repeat (3) @(negedge clk);
      check("rst_load_ready", 32'(load_ready), 32'd1);
      check("rst_maze_valid", 32'(maze_valid), 32'd0);
      check("rst_maze_bit", 32'(maze_bit), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_step_count", 32'(step_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: open maze, legal L-shaped path
      fill_open();
      load_maze();
      push_exp(3'd0, 1'b1, 9'd32);
      do_start(1'b1);
      wait_send(len);
      check("t1_send_len", 32'(len), 32'(N_CELLS));
      check("t1_bits_left", 32'(exp_bits.size()), 32'd0);
      drive_dirs(2'd0, 16);
      drive_dirs(2'd1, 16);
      end_path();
      wait_done("t1", cyc);
      check("t1_load_ready_idle", 32'(load_ready), 32'd1);
      seen_d = 0;
      for (int i = 0; i < 3; i++) begin
         path_valid = 1'b1;
         @(negedge clk);
         if (done) seen_d++;
      end
      end_path();
      repeat (2) begin
         @(negedge clk);
         if (done) seen_d++;
      end
      check("idle_pv_no_done", 32'(seen_d), 32'd0);
      check("idle_pv_pass_held", 32'(pass), 32'd1);
      check("idle_pv_steps_held", 32'(step_count), 32'd32);

      // 2: wall at (0,1), stream keeps going after the error
      maze_m[0] = 17'h1FFFD;
      load_maze();
      push_exp(3'd3, 1'b0, 9'd33);
      do_start(1'b1);
      wait_send(len);
      check("t2_send_len", 32'(len), 32'(N_CELLS));
      drive_dirs(2'd0, 1);
      drive_dirs(2'd1, 16);
      drive_dirs(2'd0, 16);
      end_path();
      wait_done("t2", cyc);

      // 3a: out of bounds on the very first move
      fill_open();
      load_maze();
      push_exp(3'd2, 1'b0, 9'd1);
      do_start(1'b1);
      wait_send(len);
      drive_dirs(2'd3, 1);
      end_path();
      wait_done("t3a", cyc);

      // 3b: step back onto the start cell
      push_exp(3'd4, 1'b0, 9'd2);
      do_start(1'b1);
      wait_send(len);
      drive_dirs(2'd0, 1);
      drive_dirs(2'd2, 1);
      end_path();
      wait_done("t3b", cyc);

      // 4: path stops one short of the goal
      push_exp(3'd5, 1'b0, 9'd31);
      do_start(1'b1);
      wait_send(len);
      drive_dirs(2'd0, 16);
      drive_dirs(2'd1, 15);
      end_path();
      wait_done("t4", cyc);

      // 5: solver silent -> timeout measured from maze_valid falling
      push_exp(3'd1, 1'b0, 9'd0);
      do_start(1'b1);
      wait_send(len);
      check("t5_send_len", 32'(len), 32'(N_CELLS));
      wait_done("t5", cyc);
      check("t5_timeout_cycles", 32'(cyc), 32'(T_OUT));

      // 6: checkerboard rows, reset in the middle of SEND
      for (int i = 0; i < N_SIDE; i++) maze_m[i] = (i % 2 == 0) ? 17'h15555 : 17'h0AAAA;
      load_maze();
      do_start(1'b1);
      repeat (99) @(negedge clk);
      check("t6_valid_at_100", 32'(maze_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_valid_drop", 32'(maze_valid), 32'd0);
      check("t6_async_bit_drop", 32'(maze_bit), 32'd0);
      exp_bits.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t6_rst_load_ready", 32'(load_ready), 32'd1);
      check("t6_rst_err_code", 32'(err_code), 32'd0);
      check("t6_rst_step_count", 32'(step_count), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen_v = 0;
      seen_d = 0;
      for (int i = 0; i < 40; i++) begin
         if (maze_valid) seen_v++;
         if (done) seen_d++;
         @(negedge clk);
      end
      check("t6_unloaded_start_valid", 32'(seen_v), 32'd0);
      check("t6_unloaded_start_done", 32'(seen_d), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
